// File: rtl/bomb_session_ctrl.sv
// bomb_session_ctrl: bomb countdown, strike/stage counting and win/lose decision for one game session.
// Optional build macro BOMB_SESSION_PENALTY_EN: wrong verdicts also cost PENALTY_SECONDS of countdown.
module bomb_session_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int START_SECONDS = 60,
  parameter int MAX_STRIKES = 3,
  parameter int STAGES_TO_WIN = 4,
  parameter int PENALTY_SECONDS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start_btn,
  input  logic [1:0] checklight,
  output logic       game_enable,
  output logic       new_round,
  output logic [7:0] seconds_left,
  output logic [1:0] strikes,
  output logic [2:0] stages_cleared,
  output logic [1:0] state
);
  localparam int DW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, DEFUSED = 2'b10, EXPLODED = 2'b11} state_t;
  state_t st;
  logic start_q;
  logic [1:0] cl_q;
  logic [DW-1:0] div;
  logic start_ev, correct, wrong, tick, win, out;
  logic [7:0] sec_t, sec_n;
`ifdef BOMB_SESSION_PENALTY_EN
  localparam logic [7:0] PEN = 8'(PENALTY_SECONDS);
`else
  logic unused_pen;
  assign unused_pen = ^8'(PENALTY_SECONDS);
`endif
  assign state = st;
  always_comb begin
    start_ev = start_btn & ~start_q;
    correct = cl_q == 2'b00 && checklight == 2'b01;
    wrong = cl_q == 2'b00 && checklight == 2'b10;
    tick = div == DW'(TICK_DIV - 1);
    sec_t = tick ? seconds_left - 8'd1 : seconds_left;
`ifdef BOMB_SESSION_PENALTY_EN
    sec_n = wrong ? (sec_t > PEN ? sec_t - PEN : 8'd0) : sec_t;
`else
    sec_n = sec_t;
`endif
    win = correct && (stages_cleared + 3'd1 == 3'(STAGES_TO_WIN));
    out = wrong && (strikes + 2'd1 == 2'(MAX_STRIKES));
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= IDLE;
      game_enable <= 1'b0;
      new_round <= 1'b0;
      seconds_left <= 8'(START_SECONDS);
      strikes <= 2'd0;
      stages_cleared <= 3'd0;
      start_q <= 1'b0;
      cl_q <= 2'b00;
      div <= '0;
    end else begin
      start_q <= start_btn;
      cl_q <= checklight;
      new_round <= 1'b0;
      if (st != ARMED && start_ev) begin
        st <= ARMED;
        game_enable <= 1'b1;
        new_round <= 1'b1;
        seconds_left <= 8'(START_SECONDS);
        strikes <= 2'd0;
        stages_cleared <= 3'd0;
        div <= '0;
      end else if (st == ARMED) begin
        div <= tick ? '0 : div + DW'(1);
        seconds_left <= sec_n;
        if (correct) stages_cleared <= stages_cleared + 3'd1;
        if (wrong) strikes <= strikes + 2'd1;
        // Win outranks both explosion causes; a non-final correct answer asks for fresh screens.
        if (win) begin
          st <= DEFUSED;
          game_enable <= 1'b0;
        end else if (out || sec_n == 8'd0) begin
          st <= EXPLODED;
          game_enable <= 1'b0;
        end else
          new_round <= correct;
      end
    end
  end
endmodule
